// File: rtl/dram_sequencer_pkg.sv
// Shared definitions for the VG8020 slot-3 DRAM sequencer: state encoding,
// default timing values and strobe decode helpers.
package dram_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ROW       = 3'd1,
      ST_COL       = 3'd2,
      ST_ACCESS    = 3'd3,
      ST_RFSH      = 3'd4,
      ST_CBR_CAS   = 3'd5,
      ST_CBR_RAS   = 3'd6,
      ST_PRECHARGE = 3'd7
   } state_t;

   localparam int DEF_RAS_TO_MUX     = 1;
   localparam int DEF_MUX_TO_CAS     = 1;
   localparam int DEF_T_RP           = 2;
   localparam int DEF_T_RFSH         = 3;
   localparam int DEF_REFRESH_PERIOD = 256;

   // Phase counter width; covers every timing parameter up to 255 cycles.
   localparam int CNT_W = 8;

   function automatic logic ras_active(input state_t s);
      return s inside {ST_ROW, ST_COL, ST_ACCESS, ST_RFSH, ST_CBR_RAS};
   endfunction

   function automatic logic col_select(input state_t s);
      return s inside {ST_COL, ST_ACCESS};
   endfunction

   function automatic logic cas_active(input state_t s);
      return s inside {ST_ACCESS, ST_CBR_CAS, ST_CBR_RAS};
   endfunction

endpackage

// File: rtl/dram_sequencer_refresh_timer.sv
// Free-running refresh interval timer with a sticky pending flag.
// Only compiled and used when AUTO_REFRESH_EN is defined.
`ifdef AUTO_REFRESH_EN
module refresh_timer
   import dram_sequencer_pkg::*;
#(
   parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic pending
);

   localparam int TW = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
   localparam logic [TW-1:0] LAST = TW'(REFRESH_PERIOD - 1);

   logic [TW-1:0] count;
   logic          wrap;

   assign wrap = (count == LAST);

   // A wrap in the same cycle as a clear starts a new interval, so set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         pending <= 1'b0;
      end else begin
         count <= wrap ? '0 : count + TW'(1);
         if (wrap)
            pending <= 1'b1;
         else if (clr)
            pending <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/dram_sequencer.sv
// VG8020 slot-3 DRAM timing sequencer: nRAS/MUX/nCAS/nWE generation and Z80 /WAIT.
// Define AUTO_REFRESH_EN to add internal CAS-before-RAS refresh.
module dram_sequencer
   import dram_sequencer_pkg::*;
#(
   parameter int RAS_TO_MUX     = DEF_RAS_TO_MUX,
   parameter int MUX_TO_CAS     = DEF_MUX_TO_CAS,
   parameter int T_RP           = DEF_T_RP,
   parameter int T_RFSH         = DEF_T_RFSH,
   parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic nmreq,
   input  logic nrd,
   input  logic nwr,
   input  logic nrfsh,
   input  logic nsltsl3,
   output logic nras,
   output logic mux,
   output logic ncas,
   output logic nwe,
   output logic nwait
);

   localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(RAS_TO_MUX - 1);
   localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(MUX_TO_CAS - 1);
   localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] RFSH_LAST = CNT_W'(T_RFSH - 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             req_s3;
   logic             z80_rfsh;
   logic             strobe;
   logic             wait_state;
   logic             rfsh_pending;
   logic             nwait_next;

   assign req_s3     = !nmreq && nrfsh && !nsltsl3;
   assign z80_rfsh   = !nmreq && !nrfsh;
   assign strobe     = !nrd || !nwr;
   assign wait_state = state inside {ST_PRECHARGE, ST_CBR_CAS, ST_CBR_RAS};

`ifdef AUTO_REFRESH_EN
   logic rfsh_clr;

   assign rfsh_clr = (state == ST_IDLE) && (next_state inside {ST_RFSH, ST_CBR_CAS});

   refresh_timer #(
      .REFRESH_PERIOD(REFRESH_PERIOD)
   ) u_refresh_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (rfsh_clr),
      .pending(rfsh_pending)
   );
`else
   localparam int unused_refresh_period = REFRESH_PERIOD;
   assign rfsh_pending = 1'b0;
`endif

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: begin
            // Z80 refresh beats a memory request; a pending CBR yields to both.
            if (z80_rfsh)
               next_state = ST_RFSH;
            else if (req_s3)
               next_state = ST_ROW;
            else if (rfsh_pending)
               next_state = ST_CBR_CAS;
         end
         ST_ROW: begin
            if (nmreq)
               next_state = ST_PRECHARGE;
            else if (cnt >= ROW_LAST)
               next_state = ST_COL;
         end
         ST_COL: begin
            if (nmreq)
               next_state = ST_PRECHARGE;
            else if ((cnt >= COL_LAST) && strobe)
               next_state = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (nmreq)
               next_state = ST_PRECHARGE;
         end
         ST_RFSH: begin
            if (nmreq)
               next_state = ST_PRECHARGE;
         end
         ST_CBR_CAS: next_state = ST_CBR_RAS;
         ST_CBR_RAS: begin
            if (cnt >= RFSH_LAST)
               next_state = ST_PRECHARGE;
         end
         ST_PRECHARGE: begin
            // A request held through precharge starts its row straight away.
            if (cnt >= RP_LAST)
               next_state = req_s3 ? ST_ROW : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase

      if (next_state != state)
         cnt_next = '0;
      else if (cnt == '1)
         cnt_next = cnt;
      else
         cnt_next = cnt + CNT_W'(1);

      nwait_next = !(req_s3 && wait_state && (next_state != ST_ROW));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         nras  <= 1'b1;
         mux   <= 1'b0;
         ncas  <= 1'b1;
         nwe   <= 1'b1;
         nwait <= 1'b1;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
         nras  <= !ras_active(next_state);
         mux   <= col_select(next_state);
         ncas  <= !cas_active(next_state);
         nwe   <= !((next_state == ST_ACCESS) && !nwr);
         nwait <= nwait_next;
      end
   end

endmodule

// File: tb/tb_dram_sequencer.sv
// Bench for dram_sequencer: directed steps plus random bus traffic against a
// transaction-level reference model; AUTO_REFRESH_EN adds CBR pattern checks.
module tb_dram_sequencer;

   localparam int RAS_TO_MUX = 1;
   localparam int MUX_TO_CAS = 1;
   localparam int T_RP       = 2;
   localparam int T_RFSH     = 3;
   localparam int PERIOD     = 256;
   localparam int PERIOD16   = 16;

   localparam int K_NONE = 0;
   localparam int K_MEM  = 1;
   localparam int K_ZR   = 2;
   localparam int K_CBR  = 3;

   logic clk;
   logic rst;
   logic nmreq, nrd, nwr, nrfsh, nsltsl3;
   logic nras, mux, ncas, nwe, nwait;
   logic nras16, mux16, ncas16, nwe16, nwait16;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the activity in progress and how long it has run.
   int m_kind, m_age, m_rp, m_cyc;
   bit m_cas, m_wr, m_pend, m_nwait;

   dram_sequencer #(
      .RAS_TO_MUX(RAS_TO_MUX), .MUX_TO_CAS(MUX_TO_CAS), .T_RP(T_RP),
      .T_RFSH(T_RFSH), .REFRESH_PERIOD(PERIOD)
   ) dut (
      .clk(clk), .rst(rst), .nmreq(nmreq), .nrd(nrd), .nwr(nwr),
      .nrfsh(nrfsh), .nsltsl3(nsltsl3),
      .nras(nras), .mux(mux), .ncas(ncas), .nwe(nwe), .nwait(nwait)
   );

   dram_sequencer #(
      .RAS_TO_MUX(RAS_TO_MUX), .MUX_TO_CAS(MUX_TO_CAS), .T_RP(T_RP),
      .T_RFSH(T_RFSH), .REFRESH_PERIOD(PERIOD16)
   ) dut16 (
      .clk(clk), .rst(rst), .nmreq(nmreq), .nrd(nrd), .nwr(nwr),
      .nrfsh(nrfsh), .nsltsl3(nsltsl3),
      .nras(nras16), .mux(mux16), .ncas(ncas16), .nwe(nwe16), .nwait(nwait16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step();
      bit req, zr, busy, started, clr;
      if (rst) begin
         m_kind = K_NONE; m_age = 0; m_rp = 0; m_cyc = 0;
         m_cas = 0; m_wr = 0; m_pend = 0; m_nwait = 1;
         return;
      end
      req     = !nmreq && nrfsh && !nsltsl3;
      zr      = !nmreq && !nrfsh;
      busy    = (m_kind == K_NONE && m_rp > 0) || m_kind == K_CBR;
      started = 0;
      clr     = 0;
      if (m_kind == K_MEM || m_kind == K_ZR) begin
         if (nmreq) begin
            m_kind = K_NONE;
            m_rp   = T_RP;
         end else if (m_kind == K_MEM) begin
            m_age++;
            if (!m_cas && m_age >= RAS_TO_MUX + MUX_TO_CAS && (!nrd || !nwr))
               m_cas = 1;
            m_wr = m_cas && !nwr;
         end
      end else if (m_kind == K_CBR) begin
         m_age++;
         if (m_age > T_RFSH) begin
            m_kind = K_NONE;
            m_rp   = T_RP;
         end
      end else if (m_rp > 0) begin
         m_rp--;
         if (m_rp == 0 && req) started = 1;
      end else if (zr) begin
         m_kind = K_ZR;
         clr    = 1;
      end else if (req) begin
         started = 1;
      end else if (m_pend) begin
         m_kind = K_CBR;
         m_age  = 0;
         clr    = 1;
      end
      if (started) begin
         m_kind = K_MEM; m_age = 0; m_cas = 0; m_wr = 0;
      end
      m_nwait = !(req && busy && !started);
      if (clr) m_pend = 0;
`ifdef AUTO_REFRESH_EN
      if (m_cyc % PERIOD == PERIOD - 1) m_pend = 1;
`endif
      m_cyc++;
   endtask

   function automatic logic [4:0] model_out();
      bit ras_lo, col, cas_lo, we_lo;
      ras_lo = m_kind == K_MEM || m_kind == K_ZR || (m_kind == K_CBR && m_age >= 1);
      col    = m_kind == K_MEM && m_age >= RAS_TO_MUX;
      cas_lo = (m_kind == K_MEM && m_cas) || m_kind == K_CBR;
      we_lo  = m_kind == K_MEM && m_cas && m_wr;
      return {!ras_lo, col, !cas_lo, !we_lo, m_nwait};
   endfunction

   function automatic logic [4:0] obs();
      return {nras, mux, ncas, nwe, nwait};
   endfunction

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
      n_checks++;
      assert (got === want) n_pass++;
      else $error("FAIL %s: observed %b, expected %b (nras,mux,ncas,nwe,nwait)", tag, got, want);
   endtask

   task automatic check2(input string tag, input logic [1:0] got, input logic [1:0] want);
      n_checks++;
      assert (got === want) n_pass++;
      else $error("FAIL %s: observed %b, expected %b", tag, got, want);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("model", obs(), model_out());
   endtask

   task automatic set_bus(input logic mreq, input logic rd, input logic wr,
                          input logic rf, input logic slt);
      nmreq = mreq; nrd = rd; nwr = wr; nrfsh = rf; nsltsl3 = slt;
   endtask

   initial begin
      int hold;
      rst = 1'b1;
      set_bus(1, 1, 1, 1, 1);
      tick();
      tick();
      check("reset", obs(), 5'b10111);
      rst = 1'b0;
      tick();
      tick();
      check("idle", obs(), 5'b10111);

      // Read with default timing.
      set_bus(0, 1, 1, 1, 0);
      tick();
      check("rd_row", obs(), 5'b00111);
      set_bus(0, 0, 1, 1, 0);
      tick();
      check("rd_mux", obs(), 5'b01111);
      tick();
      check("rd_cas", obs(), 5'b01011);
      tick(); tick(); tick();
      set_bus(1, 1, 1, 1, 1);
      tick();
      check("rd_end", obs(), 5'b10111);
      tick(); tick();

      // Write with /WR arriving late.
      set_bus(0, 1, 1, 1, 0);
      tick(); tick(); tick(); tick(); tick();
      check("wr_colhold", obs(), 5'b01111);
      set_bus(0, 1, 0, 1, 0);
      tick();
      check("wr_cas", obs(), 5'b01001);
      set_bus(1, 1, 1, 1, 1);
      tick();
      check("wr_end", obs(), 5'b10111);

      // Back-to-back request arriving in precharge.
      set_bus(0, 1, 1, 1, 0);
      tick();
      check("b2b_wait", obs(), 5'b10110);
      tick();
      check("b2b_row", obs(), 5'b00111);
      set_bus(0, 0, 1, 1, 0);
      tick(); tick();
      check("b2b_cas", obs(), 5'b01011);

      // Reset in the middle of an access; no precharge afterwards.
      rst = 1'b1;
      tick();
      check("rst_access", obs(), 5'b10111);
      rst = 1'b0;
      tick();
      check("rst_noprech", obs(), 5'b00111);
      set_bus(1, 1, 1, 1, 1);
      tick(); tick(); tick();

      // Z80 refresh, then a request that drops before service.
      set_bus(0, 1, 1, 0, 1);
      tick();
      check("zr_ras", obs(), 5'b00111);
      tick();
      check("zr_hold", obs(), 5'b00111);
      set_bus(1, 1, 1, 1, 1);
      tick();
      check("zr_end", obs(), 5'b10111);
      set_bus(0, 1, 1, 1, 0);
      tick();
      check("drop_wait", obs(), 5'b10110);
      set_bus(1, 1, 1, 1, 1);
      tick();
      check("drop_clear", obs(), 5'b10111);
      tick();
      check("drop_nostart", obs(), 5'b10111);

      // Other-slot request is ignored.
      set_bus(0, 0, 1, 1, 1);
      tick(); tick(); tick();
      check("slt1_ignore", obs(), 5'b10111);
      set_bus(1, 1, 1, 1, 1);
      tick();

      // Refresh wins over a simultaneous slot-3 request.
      set_bus(0, 1, 1, 0, 0);
      tick(); tick();
      check("prio_rfsh", obs(), 5'b00111);
      set_bus(1, 1, 1, 1, 1);
      tick(); tick(); tick();

      // Random bus traffic against the model.
      hold = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            hold    = $urandom_range(1, 8);
            nmreq   = ($urandom_range(0, 2) == 0);
            nrfsh   = ($urandom_range(0, 4) != 0);
            nsltsl3 = ($urandom_range(0, 3) == 0);
         end
         hold--;
         nrd = ($urandom_range(0, 2) != 0);
         nwr = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      set_bus(1, 1, 1, 1, 1);
      tick(); tick(); tick();

`ifdef AUTO_REFRESH_EN
      // CBR pattern on the 16-cycle instance, idle bus, then a request in CBR_RAS.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 54; k++) begin
         int  ph;
         bit  e_ncas, e_nras;
         tick();
         e_ncas = 1;
         e_nras = 1;
         if (k >= 17) begin
            ph     = (k - 17) % 16;
            e_ncas = !(ph <= 3);
            e_nras = !(ph >= 1 && ph <= 3);
         end
         check2("cbr_strobes", {nras16, ncas16}, {e_nras, e_ncas});
         if (k >= 51)
            check2("cbr_wait", {nras16, nwait16}, {e_nras, 1'b0});
         if (k == 50)
            set_bus(0, 1, 1, 1, 0);
      end
      tick();
      check2("cbr_row", {nras16, nwait16}, 2'b01);
      set_bus(1, 1, 1, 1, 1);
      tick(); tick(); tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
